mm_acc_ctrl: RTL and testbench

//  Tile sequencer for the mm_acc accumulator buffer. Accepts one tile config, then sequences three phases:
//  - optional preload of the compute bank
//  - K accumulation passes over M rows, one write per psum beat
//  - ping-pong swap and store drain of the finished bank.

---
 rtl/mm_acc_pkg.sv | 21 ++
 rtl/mm_acc_st_seq.sv | 46 ++++
 rtl/mm_acc_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mm_acc_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_acc_pkg.sv
// Shared types and widths for the mm_acc accumulator buffer and its tile sequencer.
package mm_acc_pkg;

  localparam int unsigned ACC_ADDR_W = 11;
  localparam int unsigned ACC_KP_W   = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRELOAD   = 2'd1,
    ACCUM     = 2'd2,
    SWAP_WAIT = 2'd3
  } comp_state_e;

  typedef enum logic [1:0] {
    ACC_W8   = 2'd0,
    ACC_W16  = 2'd1,
    ACC_W32  = 2'd2,
    ACC_WRSV = 2'd3
  } acc_width_e;

endpackage

// File: rtl/mm_acc_st_seq.sv
// Store-drain sequencer: walks the finished bank from row 0 to rows-1 under st_ready backpressure.
module mm_acc_st_seq
  import mm_acc_pkg::*;
#(
  parameter int unsigned ADDR_W = ACC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] rows,
  input  logic              st_ready,
  output logic              st_rd_val,
  output logic [ADDR_W-1:0] st_rd_addr,
  output logic              st_last,
  output logic              drain_done
);

  logic [ADDR_W-1:0] rows_q;

  assign st_last = st_rd_val & (st_rd_addr == rows_q - ADDR_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_rd_val  <= 1'b0;
      st_rd_addr <= '0;
      rows_q     <= '0;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      if (start) begin
        st_rd_val  <= 1'b1;
        st_rd_addr <= '0;
        rows_q     <= rows;
      end else if (st_rd_val && st_ready) begin
        if (st_last) begin
          st_rd_val  <= 1'b0;
          st_rd_addr <= '0;
          drain_done <= 1'b1;
        end else begin
          st_rd_addr <= st_rd_addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mm_acc_ctrl.sv
// Tile sequencer for mm_acc: preload, K accumulation passes over M rows, then bank swap and drain.
// Optional MM_ACC_CTRL_PERF_EN adds saturating busy/stall cycle counters.
module mm_acc_ctrl
  import mm_acc_pkg::*;
#(
  parameter int unsigned ADDR_W = ACC_ADDR_W,
  parameter int unsigned KP_W   = ACC_KP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_rows,
  input  logic [KP_W-1:0]   cfg_kpasses,
  input  logic [1:0]        cfg_width,
  input  logic [4:0]        cfg_byte_shft,
  input  logic              cfg_preload,
  input  logic              psum_val,
  input  logic              pl_val,
  output logic              pl_ready,
  input  logic              st_ready,
  output logic              acc_wr_en,
  output logic [ADDR_W-1:0] acc_wr_addr,
  output logic [1:0]        acc_width,
  output logic [4:0]        byte_shft,
  output logic              acc_en,
  output logic              ping_pong,
  output logic              preload_acc_en,
  output logic [ADDR_W-1:0] preload_wr_addr,
  output logic [ADDR_W-1:0] st_rd_addr,
  output logic              st_rd_val,
  output logic              st_last,
  output logic              busy,
  output logic              tile_done,
  output logic              drain_done,
  output logic              cfg_err,
`ifdef MM_ACC_CTRL_PERF_EN
  output logic [31:0]       perf_busy_cyc,
  output logic [31:0]       perf_stall_cyc,
`endif
  output logic              seq_err
);

  comp_state_e       state;
  acc_width_e        width_q;
  logic [ADDR_W-1:0] row, rows_q;
  logic [KP_W-1:0]   pass, kp_q;
  logic              pre_q;
  logic              cfg_hs, cfg_bad, row_last, pass_last, swap_go;

  assign cfg_hs    = cfg_valid & cfg_ready;
  assign cfg_bad   = (cfg_rows == '0) | (cfg_kpasses == '0);
  assign row_last  = (row == rows_q - ADDR_W'(1));
  assign pass_last = (pass == kp_q - KP_W'(1));
  assign swap_go   = (state == SWAP_WAIT) & ~st_rd_val;

  // Write-side controls are same-cycle so they line up with the array's data beat.
  assign busy            = (state != IDLE);
  assign pl_ready        = (state == PRELOAD);
  assign preload_acc_en  = pl_ready & pl_val;
  assign preload_wr_addr = pl_ready ? row : '0;
  assign acc_wr_en       = (state == ACCUM) & psum_val;
  assign acc_wr_addr     = (state == ACCUM) ? row : '0;
  assign acc_en          = (state == ACCUM) & ~((pass == '0) & ~pre_q);
  assign acc_width       = width_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      pass      <= '0;
      rows_q    <= '0;
      kp_q      <= '0;
      pre_q     <= 1'b0;
      width_q   <= ACC_W8;
      byte_shft <= '0;
      cfg_ready <= 1'b0;
      ping_pong <= 1'b0;
      tile_done <= 1'b0;
      cfg_err   <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      cfg_err   <= 1'b0;
      if (psum_val && state != ACCUM) seq_err <= 1'b1;
      case (state)
        IDLE: begin
          cfg_ready <= 1'b1;
          if (cfg_hs) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              rows_q    <= cfg_rows;
              kp_q      <= cfg_kpasses;
              pre_q     <= cfg_preload;
              width_q   <= acc_width_e'(cfg_width);
              byte_shft <= cfg_byte_shft;
              row       <= '0;
              pass      <= '0;
              cfg_ready <= 1'b0;
              state     <= cfg_preload ? PRELOAD : ACCUM;
            end
          end
        end
        PRELOAD: begin
          if (pl_val) begin
            if (row_last) begin
              row   <= '0;
              state <= ACCUM;
            end else begin
              row <= row + ADDR_W'(1);
            end
          end
        end
        ACCUM: begin
          if (psum_val) begin
            if (row_last) begin
              row <= '0;
              if (pass_last) begin
                pass  <= '0;
                state <= SWAP_WAIT;
              end else begin
                pass <= pass + KP_W'(1);
              end
            end else begin
              row <= row + ADDR_W'(1);
            end
          end
        end
        SWAP_WAIT: begin
          // Swap only once the previous bank has fully drained.
          if (swap_go) begin
            ping_pong <= ~ping_pong;
            tile_done <= 1'b1;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mm_acc_st_seq #(.ADDR_W(ADDR_W)) u_st_seq (
    .clk        (clk),
    .rst        (rst),
    .start      (swap_go),
    .rows       (rows_q),
    .st_ready   (st_ready),
    .st_rd_val  (st_rd_val),
    .st_rd_addr (st_rd_addr),
    .st_last    (st_last),
    .drain_done (drain_done)
  );

`ifdef MM_ACC_CTRL_PERF_EN
  logic [1:0]  stall_inc;
  logic [32:0] stall_sum;

  assign stall_inc = 2'(state == SWAP_WAIT) + 2'(st_rd_val & ~st_ready);
  assign stall_sum = {1'b0, perf_stall_cyc} + 33'(stall_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (busy && perf_busy_cyc != '1) perf_busy_cyc <= perf_busy_cyc + 32'd1;
      perf_stall_cyc <= stall_sum[32] ? '1 : stall_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_mm_acc_ctrl.sv
// Self-checking bench for mm_acc_ctrl: behavioural queue model plus directed literal pins.
// Build with MM_ACC_CTRL_PERF_EN to also check the perf counters.
module tb_mm_acc_ctrl;
  import mm_acc_pkg::*;

  localparam int unsigned ADDR_W = ACC_ADDR_W;
  localparam int unsigned KP_W   = ACC_KP_W;

  logic clk = 1'b0, rst = 1'b1;
  logic cfg_valid = 1'b0, cfg_ready, cfg_preload = 1'b0;
  logic [ADDR_W-1:0] cfg_rows = '0;
  logic [KP_W-1:0]   cfg_kpasses = '0;
  logic [1:0] cfg_width = '0;
  logic [4:0] cfg_byte_shft = '0;
  logic psum_val = 1'b0, pl_val = 1'b0, pl_ready, st_ready = 1'b0;
  logic acc_wr_en, acc_en, ping_pong, preload_acc_en, st_rd_val, st_last;
  logic busy, tile_done, drain_done, cfg_err, seq_err;
  logic [ADDR_W-1:0] acc_wr_addr, preload_wr_addr, st_rd_addr;
  logic [1:0] acc_width;
  logic [4:0] byte_shft;
`ifdef MM_ACC_CTRL_PERF_EN
  logic [31:0] perf_busy_cyc, perf_stall_cyc;
  logic [31:0] m_busy = '0, m_stall = '0;
`endif

  mm_acc_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_rows(cfg_rows), .cfg_kpasses(cfg_kpasses), .cfg_width(cfg_width),
    .cfg_byte_shft(cfg_byte_shft), .cfg_preload(cfg_preload),
    .psum_val(psum_val), .pl_val(pl_val), .pl_ready(pl_ready), .st_ready(st_ready),
    .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr), .acc_width(acc_width),
    .byte_shft(byte_shft), .acc_en(acc_en), .ping_pong(ping_pong),
    .preload_acc_en(preload_acc_en), .preload_wr_addr(preload_wr_addr),
    .st_rd_addr(st_rd_addr), .st_rd_val(st_rd_val), .st_last(st_last),
    .busy(busy), .tile_done(tile_done), .drain_done(drain_done),
    .cfg_err(cfg_err),
`ifdef MM_ACC_CTRL_PERF_EN
    .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc),
`endif
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: expected beats per tile, pending swap and drain progress.
  int  exp_pl[$], exp_wr_a[$];
  bit  exp_wr_e[$];
  bit  tile_pending = 0, sw = 0, exp_td = 0, exp_dd = 0, exp_ce = 0;
  bit  draining = 0, m_pp = 0, m_seq = 0, rst_prev = 1;
  int  d_idx = 0, d_rows = 0, done_rows = 0, m_width = 0, m_shft = 0;
  longint cyc = 0, last_wr_cyc = 0, td_cyc = 0, dd_cyc = 0, td_gap = 0;
  int  wr_log_a[$], pl_log[$], st_log[$], last_log[$];
  bit  wr_log_e[$];
  int  td_cnt = 0, ce_cnt = 0;
  int  psum_pct = 100, pl_pct = 100, st_pct = 100;
  bit  force_psum = 0;

  // Random beat driver, only offering data when the model says the phase is open.
  initial begin
    forever begin
      @(posedge clk); #1;
      psum_val = force_psum || (exp_pl.size() == 0 && exp_wr_a.size() > 0 &&
                                $urandom_range(99) < psum_pct);
      pl_val   = exp_pl.size() > 0 && $urandom_range(99) < pl_pct;
      st_ready = $urandom_range(99) < st_pct;
    end
  end

  always @(negedge clk) begin
    bit pl_ph, ac_ph, in_sw, dr_now;
    cyc++;
    if (rst) begin
      chk("rst_acc_wr_en", acc_wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ping_pong", ping_pong, 0);
      chk("rst_st_rd_val", st_rd_val, 0);
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_seq_err", seq_err, 0);
      chk("rst_tile_done", tile_done, 0);
      exp_pl.delete(); exp_wr_a.delete(); exp_wr_e.delete();
      tile_pending = 0; sw = 0; exp_td = 0; exp_dd = 0; exp_ce = 0; draining = 0;
      m_pp = 0; m_seq = 0; m_width = 0; m_shft = 0; rst_prev = 1;
`ifdef MM_ACC_CTRL_PERF_EN
      m_busy = '0; m_stall = '0;
`endif
    end else begin
      chk("tile_done", tile_done, exp_td);
      if (tile_done) begin td_cnt++; td_cyc = cyc; td_gap = cyc - dd_cyc; end
      if (exp_td) begin
        m_pp = ~m_pp; draining = 1; d_idx = 0; d_rows = done_rows; tile_pending = 0;
      end
      exp_td = 0;
      chk("ping_pong", ping_pong, m_pp);
      chk("drain_done", drain_done, exp_dd);
      if (drain_done) dd_cyc = cyc;
      exp_dd = 0;
      chk("cfg_err", cfg_err, exp_ce);
      if (cfg_err) ce_cnt++;
      exp_ce = 0;
      chk("busy", busy, tile_pending);
      if (!rst_prev) chk("cfg_ready", cfg_ready, !tile_pending);
      chk("acc_width", acc_width, m_width);
      chk("byte_shft", byte_shft, m_shft);
      in_sw = sw;
      if (sw && !draining) begin exp_td = 1; sw = 0; end
      pl_ph = exp_pl.size() > 0;
      ac_ph = !pl_ph && exp_wr_a.size() > 0;
      chk("pl_ready", pl_ready, pl_ph);
      chk("preload_acc_en", preload_acc_en, pl_val && pl_ph);
      if (pl_val && pl_ph) begin
        chk("preload_wr_addr", preload_wr_addr, exp_pl[0]);
        pl_log.push_back(int'(preload_wr_addr));
        void'(exp_pl.pop_front());
      end
      chk("acc_wr_en", acc_wr_en, psum_val && ac_ph);
      if (psum_val && ac_ph) begin
        chk("acc_wr_addr", acc_wr_addr, exp_wr_a[0]);
        chk("acc_en", acc_en, exp_wr_e[0]);
        wr_log_a.push_back(int'(acc_wr_addr)); wr_log_e.push_back(acc_en);
        void'(exp_wr_a.pop_front()); void'(exp_wr_e.pop_front());
        last_wr_cyc = cyc;
        if (exp_wr_a.size() == 0) sw = 1;
      end
      dr_now = draining;
      chk("st_rd_val", st_rd_val, draining);
      if (draining) begin
        chk("st_rd_addr", st_rd_addr, d_idx);
        chk("st_last", st_last, d_idx == d_rows - 1);
        if (st_ready) begin
          st_log.push_back(int'(st_rd_addr));
          if (st_last) last_log.push_back(int'(st_rd_addr));
          d_idx++;
          if (d_idx == d_rows) begin draining = 0; exp_dd = 1; end
        end
      end
      chk("seq_err", seq_err, m_seq);
      if (psum_val && !ac_ph) m_seq = 1;
`ifdef MM_ACC_CTRL_PERF_EN
      chk("perf_busy_cyc", perf_busy_cyc, m_busy);
      chk("perf_stall_cyc", perf_stall_cyc, m_stall);
      if (tile_pending && m_busy != 32'hFFFF_FFFF) m_busy++;
      begin
        longint s = longint'(m_stall) + longint'(in_sw) + longint'(dr_now && !st_ready);
        m_stall = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
      end
`endif
      if (cfg_valid && cfg_ready) begin
        if (cfg_rows == 0 || cfg_kpasses == 0) exp_ce = 1;
        else begin
          if (cfg_preload) for (int r = 0; r < int'(cfg_rows); r++) exp_pl.push_back(r);
          for (int p = 0; p < int'(cfg_kpasses); p++)
            for (int r = 0; r < int'(cfg_rows); r++) begin
              exp_wr_a.push_back(r); exp_wr_e.push_back(p > 0 || cfg_preload);
            end
          tile_pending = 1; done_rows = int'(cfg_rows);
          m_width = int'(cfg_width); m_shft = int'(cfg_byte_shft);
        end
      end
      rst_prev = 0;
    end
  end

  function automatic bit cond(input int which);
    case (which)
      0: return !tile_pending && !draining && !exp_dd && !exp_td && !sw &&
                exp_pl.size() == 0 && exp_wr_a.size() == 0;
      1: return !tile_pending;
      2: return wr_log_a.size() >= 6;
      default: return exp_pl.size() == 0 && exp_wr_a.size() == 0;
    endcase
  endfunction

  task automatic wait_until(input int which, input string name);
    int n = 0;
    while (!cond(which) && n < 30000) begin @(posedge clk); n++; end
    if (!cond(which)) begin
      checks++; errors++;
      $display("FAIL timeout_%s actual=pending required=done", name);
    end
  endtask

  task automatic send(input int rows, input int k, input bit pre);
    int n = 0;
    @(posedge clk); #1;
    cfg_valid = 1; cfg_rows = ADDR_W'(rows); cfg_kpasses = KP_W'(k); cfg_preload = pre;
    cfg_width = 2'($urandom); cfg_byte_shft = 5'($urandom);
    @(negedge clk);
    while (!cfg_ready && n < 30000) begin @(negedge clk); n++; end
    if (!cfg_ready) begin
      checks++; errors++;
      $display("FAIL cfg_accept actual=0 required=1");
    end
    @(posedge clk); #1;
    cfg_valid = 0;
  endtask

  task automatic clear_logs();
    wr_log_a.delete(); wr_log_e.delete(); pl_log.delete(); st_log.delete(); last_log.delete();
    td_cnt = 0; ce_cnt = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1_a[8], t1_e[8];
    t1_a = '{0, 1, 2, 3, 0, 1, 2, 3};
    t1_e = '{0, 0, 0, 0, 1, 1, 1, 1};
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // T1: rows=4, K=2, continuous beats
    clear_logs();
    send(4, 2, 0);
    wait_until(0, "t1");
    chk("t1_wr_count", wr_log_a.size(), 8);
    for (int i = 0; i < 8 && i < wr_log_a.size(); i++) begin
      chk("t1_wr_addr", wr_log_a[i], t1_a[i]);
      chk("t1_acc_en", wr_log_e[i], t1_e[i]);
    end
    chk("t1_td_after_last_wr", td_cyc - last_wr_cyc, 2);
    chk("t1_pp", ping_pong, 1);
    chk("t1_td_cnt", td_cnt, 1);
    chk("t1_drain_cnt", st_log.size(), 4);
    for (int i = 0; i < st_log.size(); i++) chk("t1_drain_addr", st_log[i], i);
    chk("t1_last_cnt", last_log.size(), 1);
    if (last_log.size() > 0) chk("t1_last_addr", last_log[0], 3);

    // T2: preload with gapped pl_val
    clear_logs();
    pl_pct = 50;
    send(3, 1, 1);
    wait_until(0, "t2");
    chk("t2_pl_cnt", pl_log.size(), 3);
    for (int i = 0; i < pl_log.size(); i++) chk("t2_pl_addr", pl_log[i], i);
    chk("t2_wr_cnt", wr_log_a.size(), 3);
    for (int i = 0; i < wr_log_e.size(); i++) chk("t2_acc_en", wr_log_e[i], 1);
    chk("t2_pp", ping_pong, 0);

    // T3: back-to-back tiles with the store stalled
    clear_logs();
    st_pct = 0;
    send(2, 1, 0);
    wait_until(1, "t3a");
    send(2, 1, 0);
    wait_until(3, "t3b");
    repeat (10) @(posedge clk);
    #3;
    chk("t3_cfg_ready_hold", cfg_ready, 0);
    chk("t3_busy_hold", busy, 1);
    chk("t3_pp_hold", ping_pong, 1);
    st_pct = 100;
    wait_until(0, "t3");
    chk("t3_pp_final", ping_pong, 0);
    chk("t3_swap_after_drain_done", td_gap, 1);
    chk("t3_td_cnt", td_cnt, 2);

    // T4: zero rows is rejected
    clear_logs();
    send(0, 2, 0);
    repeat (4) @(posedge clk);
    #3;
    chk("t4_cfg_err_cnt", ce_cnt, 1);
    chk("t4_no_writes", wr_log_a.size(), 0);
    chk("t4_pp", ping_pong, 0);

    // T5: stray psum_val, then reset mid-ACCUM at row 2 pass 1
    clear_logs();
    @(posedge clk); #2 force_psum = 1;
    @(posedge clk); #2 force_psum = 0;
    repeat (3) @(posedge clk);
    #3 chk("t5_seq_err_set", seq_err, 1);
    send(4, 3, 0);
    wait_until(2, "t5_mid");
    #3 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #3;
    chk("t5_seq_err_cleared", seq_err, 0);
    chk("t5_busy_cleared", busy, 0);
    chk("t5_pp_cleared", ping_pong, 0);

    // T6: full-depth tiles and random small tiles with random gaps
    psum_pct = 70; pl_pct = 60; st_pct = 60;
    send(2047, 2, 0);
    send(2047, 1, 1);
    for (int t = 0; t < 12; t++) begin
      st_pct = 30 + $urandom_range(60);
      send(1 + $urandom_range(8), 1 + $urandom_range(3), 1'($urandom));
    end
    wait_until(0, "t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
